// File: rtl/k_alu_pkg.sv
// Shared definitions for the ALU lane return path: word width and the
// source-select encoding common to the 1-to-2 demux and the 2-to-1 merge.
package k_alu_pkg;

  localparam int WORD_W = 16;

  localparam logic SEL_IN0 = 1'b0;
  localparam logic SEL_IN1 = 1'b1;

  typedef logic [WORD_W-1:0] word_t;

  // One-hot grant vector for a select index.
  function automatic logic [1:0] sel_onehot(input logic sel);
    return (sel == SEL_IN1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin arbiter, purely combinational. The caller owns
// last_sel and updates it only when a grant is actually consumed.
module rr_arbiter_2
  import k_alu_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_sel,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  always_comb begin
    // NOTE: every output of an always_comb gets a default before any branch,
    // otherwise an uncovered path holds the old value and infers a latch.
    gnt_idx = SEL_IN0;
    gnt     = 2'b00;
    unique case (req)
      2'b01:   gnt_idx = SEL_IN0;
      2'b10:   gnt_idx = SEL_IN1;
      2'b11:   gnt_idx = ~last_sel;
      default: gnt_idx = SEL_IN0;
    endcase
    if (req != 2'b00) gnt = sel_onehot(gnt_idx);
  end

endmodule

// File: rtl/stream_merge_2to1_16b.sv
// Merges two valid/ready streams into one registered output stream with
// round-robin arbitration on ties; out_sel tags the winning source.
module stream_merge_2to1_16b
  import k_alu_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [1:0] gnt;
  logic       gnt_idx;
  logic       last_sel;
  logic       can_load;
  logic       load;

  rr_arbiter_2 u_arb (
    .req      ({in1_valid, in0_valid}),
    .last_sel (last_sel),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx)
  );

  // The register can take a word when empty or when its word leaves this cycle.
  assign can_load  = !out_valid || out_ready;
  assign load      = can_load && (gnt != 2'b00) && !rst;
  assign in0_ready = load && gnt[0];
  assign in1_ready = load && gnt[1];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= SEL_IN0;
      last_sel  <= SEL_IN1;
    end else if (load) begin
      out_data  <= (gnt_idx == SEL_IN1) ? in1_data : in0_data;
      out_sel   <= gnt_idx;
      out_valid <= 1'b1;
      last_sel  <= gnt_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
